// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Front-end fetch stage. Generates the PC, drives the word
//                index into a combinational instruction memory, and registers
//                the returned instruction into an IF/ID latch that decode
//                consumes over a valid/ready handshake. Execute can redirect
//                the PC. A misaligned or out-of-range fetch target halts the
//                unit until reset.
//  Options     : FETCH_PERF_CNT_EN - adds saturating fetch_count/flush_count
//                outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    IMEM_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  id_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_err,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           fetch_count,
    output logic [15:0]           flush_count,
`endif
    output logic                  halted
);

    localparam logic [31:0]           c_nop     = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] c_depth   = ADDR_WIDTH'(IMEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);
    // A bad reset vector is caught in BOOT so the first fetch never issues.
    localparam logic c_reset_pc_bad = (RESET_PC[1:0] != 2'b00) ||
                                      ((RESET_PC >> 2) >= c_depth);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_if_valid;
    logic [31:0]             r_if_instr;
    logic [ADDR_WIDTH-1:0]   r_if_pc;
    logic                    r_fetch_err;
    logic                    r_halted;

    logic                    w_in_fetch;
    logic                    w_pc_bad;
    logic                    w_adv;
    logic                    w_redirect;
    logic                    w_fault;
    logic                    w_load;

    // Fetch-side decisions. Redirect outranks everything; the range check only
    // matters when a fetch would actually be committed to the latch, so a
    // stalled valid instruction is never thrown away by a bad upcoming PC.
    always_comb begin
        w_in_fetch = (r_state == ST_FETCH);
        w_pc_bad   = (r_pc[1:0] != 2'b00) || ((r_pc >> 2) >= c_depth);
        w_adv      = !r_if_valid || id_ready;
        w_redirect = w_in_fetch && redirect_valid;
        w_fault    = w_in_fetch && !redirect_valid && w_adv && w_pc_bad;
        w_load     = w_in_fetch && !redirect_valid && w_adv && !w_pc_bad;
    end

    // Fetch FSM together with the PC and the IF/ID latch it controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_instr  <= c_nop;
            r_if_pc     <= '0;
            r_fetch_err <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (c_reset_pc_bad) begin
                        r_state     <= ST_HALT;
                        r_fetch_err <= 1'b1;
                        r_halted    <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_redirect) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= redirect_pc;
                    end else if (w_fault) begin
                        r_if_valid  <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_halted    <= 1'b1;
                        r_state     <= ST_HALT;
                    end else if (w_load) begin
                        r_if_instr <= imem_instr;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= r_pc + c_pc_step;
                    end
                end
                ST_HALT: begin
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    // Unused encoding: park safely until reset.
                    r_state    <= ST_HALT;
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr = r_pc >> 2;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign fetch_err = r_fetch_err;
    assign halted    = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [15:0] r_flush_count;

    // Saturating event counters: latch loads and redirect flushes. In FETCH a
    // redirect always discards at least the fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_load && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_redirect && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Directed scenarios
//                plus a randomized handshake/redirect run scored against a
//                transaction-level model of the expected instruction stream.
//                A second instance with IMEM_DEPTH=4 covers sequential overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (IMEM_DEPTH = 512)
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;
    logic        halted;

    // Overflow instance (IMEM_DEPTH = 4)
    logic        rst_n2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic        id_ready2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        fetch_err2;
    logic        halted2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
    logic [31:0] fetch_count2;
    logic [15:0] flush_count2;
`endif

    logic [31:0] mem [0:511];

    int checks   = 0;
    int failures = 0;

    assign imem_instr  = (imem_addr  < 32'd512) ? mem[imem_addr[8:0]]  : 32'h0;
    assign imem_instr2 = (imem_addr2 < 32'd512) ? mem[imem_addr2[8:0]] : 32'h0;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (512)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .flush_count    (flush_count),
`endif
        .halted         (halted)
    );

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (4)
    ) u_ovf (
        .clk            (clk),
        .rst_n          (rst_n2),
        .imem_addr      (imem_addr2),
        .imem_instr     (imem_instr2),
        .if_valid       (if_valid2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2),
        .id_ready       (id_ready2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .fetch_err      (fetch_err2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count2),
        .flush_count    (flush_count2),
`endif
        .halted         (halted2)
    );

    // Hold reset over two cycles, releasing on a falling edge; the next rising
    // edge is the BOOT cycle.
    task automatic reset_dut(input logic ready);
        rst_n          = 1'b0;
        id_ready       = ready;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0h exp=0", if_valid); end
        checks++; if (if_instr !== 32'h13) begin failures++; $display("FAIL reset_if_instr got=%0h exp=13", if_instr); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%0h exp=0", if_pc); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%0h exp=0", fetch_err); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_fetch_count got=%0h exp=0", fetch_count); end
        checks++; if (flush_count !== 16'h0) begin failures++; $display("FAIL reset_flush_count got=%0h exp=0", flush_count); end
`endif
    endtask

    task automatic test_boot;
        reset_dut(1'b1);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_c1_valid got=%0h exp=0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL boot_c2_valid got=%0h exp=1", if_valid); end
        checks++; if (if_instr !== 32'h004182b3) begin failures++; $display("FAIL boot_c2_instr got=%0h exp=004182b3", if_instr); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL boot_c2_pc got=%0h exp=0", if_pc); end
        @(negedge clk);
        checks++; if (if_instr !== 32'h40418333) begin failures++; $display("FAIL boot_c3_instr got=%0h exp=40418333", if_instr); end
        checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL boot_c3_pc got=%0h exp=4", if_pc); end
    endtask

    // Continues directly from test_boot (if_pc = 4 on entry).
    task automatic test_stall;
        @(negedge clk);
        checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stall_entry_pc got=%0h exp=8", if_pc); end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stall_hold_pc cyc=%0d got=%0h exp=8", i, if_pc); end
            checks++; if (imem_addr !== 32'h3) begin failures++; $display("FAIL stall_hold_addr cyc=%0d got=%0h exp=3", i, imem_addr); end
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid cyc=%0d got=%0h exp=1", i, if_valid); end
        end
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (if_pc !== 32'hC) begin failures++; $display("FAIL stall_release_pc got=%0h exp=c", if_pc); end
        checks++; if (if_instr !== mem[3]) begin failures++; $display("FAIL stall_release_instr got=%0h exp=%0h", if_instr, mem[3]); end
    endtask

    task automatic test_redirect;
        reset_dut(1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL redir_entry_pc got=%0h exp=4", if_pc); end
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble_valid got=%0h exp=0", if_valid); end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL redir_target_valid got=%0h exp=1", if_valid); end
        checks++; if (if_pc !== 32'h1C) begin failures++; $display("FAIL redir_target_pc got=%0h exp=1c", if_pc); end
        checks++; if (if_instr !== 32'h0020A103) begin failures++; $display("FAIL redir_target_instr got=%0h exp=0020a103", if_instr); end
    endtask

    // Continues from test_redirect in FETCH.
    task automatic test_misaligned;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL misal_bubble_valid got=%0h exp=0", if_valid); end
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL misal_fetch_err got=%0h exp=1", fetch_err); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL misal_halted got=%0h exp=1", halted); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL misal_valid got=%0h exp=0", if_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky cyc=%0d got=%0h exp=1", i, halted); end
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_valid cyc=%0d got=%0h exp=0", i, if_valid); end
            checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL halt_pc_frozen cyc=%0d got=%0h exp=8", i, imem_addr); end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_overflow;
        int n;
        n = 0;
        rst_n2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_valid2 === 1'b1) begin
                checks++; if (if_pc2 !== 32'(n * 4)) begin failures++; $display("FAIL ovf_pc idx=%0d got=%0h exp=%0h", n, if_pc2, n * 4); end
                checks++; if (if_instr2 !== mem[n % 512]) begin failures++; $display("FAIL ovf_instr idx=%0d got=%0h exp=%0h", n, if_instr2, mem[n % 512]); end
                n++;
            end
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", n); end
        checks++; if (fetch_err2 !== 1'b1) begin failures++; $display("FAIL ovf_fetch_err got=%0h exp=1", fetch_err2); end
        checks++; if (halted2 !== 1'b1) begin failures++; $display("FAIL ovf_halted got=%0h exp=1", halted2); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count2 !== 32'd4) begin failures++; $display("FAIL ovf_fetch_count got=%0d exp=4", fetch_count2); end
`endif
    endtask

    task automatic test_async_reset;
        bit found;
        found = 1'b0;
        reset_dut(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1 && if_pc === 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL areset_reach_pc10 got=%0h exp=1", found); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL areset_pc got=%0h exp=0", if_pc); end
        checks++; if (if_instr !== 32'h13) begin failures++; $display("FAIL areset_instr got=%0h exp=13", if_instr); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL areset_addr got=%0h exp=0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL areset_fetch_count got=%0h exp=0", fetch_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL areset_boot_valid got=%0h exp=0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL areset_refetch_valid got=%0h exp=1", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL areset_refetch_pc got=%0h exp=0", if_pc); end
    endtask

    // Transaction-level scoreboard: tracks which byte PC decode should see
    // next and whether the latch should be holding it.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        logic [31:0] tgt;
        bit          exp_valid;
        bit          redir;
        int          exp_fetches;
        int          exp_flushes;
        reset_dut(1'b0);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rand_boot_valid got=%0h exp=0", if_valid); end
        exp_pc      = 32'h0;
        exp_valid   = 1'b0;
        exp_fetches = 0;
        exp_flushes = 0;
        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redir          = ($urandom_range(0, 9) == 0);
            tgt            = 32'($urandom_range(0, 100)) << 2;
            redirect_valid = redir;
            redirect_pc    = tgt;
            if (redir) begin
                exp_pc    = tgt;
                exp_valid = 1'b0;
                exp_flushes++;
            end else if (!exp_valid) begin
                exp_valid = 1'b1;
                exp_fetches++;
            end else if (id_ready) begin
                exp_pc = exp_pc + 32'd4;
                exp_fetches++;
            end
            @(negedge clk);
            checks++; if (if_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0h exp=%0h", i, if_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (if_pc !== exp_pc) begin failures++; $display("FAIL rand_pc cyc=%0d got=%0h exp=%0h", i, if_pc, exp_pc); end
                checks++; if (if_instr !== mem[exp_pc[10:2]]) begin failures++; $display("FAIL rand_instr cyc=%0d got=%0h exp=%0h", i, if_instr, mem[exp_pc[10:2]]); end
            end
            exp_addr = (exp_valid ? exp_pc + 32'd4 : exp_pc) >> 2;
            checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%0h exp=%0h", i, imem_addr, exp_addr); end
        end
        redirect_valid = 1'b0;
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rand_no_err got=%0h exp=0", fetch_err); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'(exp_fetches)) begin failures++; $display("FAIL rand_fetch_count got=%0d exp=%0d", fetch_count, exp_fetches); end
        checks++; if (flush_count !== 16'(exp_flushes)) begin failures++; $display("FAIL rand_flush_count got=%0d exp=%0d", flush_count, exp_flushes); end
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        rst_n2          = 1'b0;
        id_ready        = 1'b0;
        id_ready2       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        redirect_valid2 = 1'b0;
        redirect_pc2    = 32'h0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = $urandom;
        end
        mem[0] = 32'h004182b3;
        mem[1] = 32'h40418333;
        mem[7] = 32'h0020A103;

        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_misaligned();
        test_overflow();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog_timeout got=expired exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage that generates the program counter and drives the word index into the combinational instruction memory.
- Registers the returned instruction into an IF/ID latch, handing PC and instruction to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and halts on misaligned or out-of-range fetch targets.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction memory address/data.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_DEPTH, 512, number of 32-bit words in instruction memory; valid byte range is 0 .. 4*IMEM_DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_WIDTH  word index to instruction memory = pc >> 2 (combinational from pc register).
- imem_instr  input  32  instruction returned combinationally by instruction memory.
- if_valid  output  1  IF/ID latch holds a valid instruction.
- if_instr  output  32  latched instruction.
- if_pc  output  ADDR_WIDTH  byte PC of if_instr.
- id_ready  input  1  decode accepts the latch this cycle.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  ADDR_WIDTH  redirect target byte address.
- fetch_err  output  1  sticky: misaligned or out-of-range target seen.
- halted  output  1  unit is in HALT state.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; if_valid=0; if_instr=32'h0000_0013 (NOP); if_pc=0; fetch_err=0; halted=0; state=BOOT.
- FSM states: BOOT, FETCH, HALT.
- BOOT: one cycle with no fetch and if_valid=0, then FETCH. If RESET_PC is misaligned or out of range, go to HALT with fetch_err=1.
- FETCH, advance condition: adv = !if_valid | id_ready.
  - On adv: if_instr<=imem_instr; if_pc<=pc; if_valid<=1; pc<=pc+4. Addition is modulo 2^ADDR_WIDTH.
  - Without adv: pc and the latch hold.
  - One instruction per cycle at full throughput; latency from pc to if_valid is 1 cycle.
- Redirect: highest priority, evaluated in FETCH only.
  - Drops the latch (if_valid<=0) even if id_ready=1 this cycle; the current fetch is discarded.
  - pc<=redirect_pc; the target is fetched the following cycle.
  - Redirect-to-latch bubble is 1 cycle.
- Range check: before each fetch, pc[1:0]!=0 or (pc>>2)>=IMEM_DEPTH triggers the error path.
  - No latch update; fetch_err<=1; state<=HALT.
  - Covers both sequential overflow past the last word and a bad redirect target.
- HALT: if_valid<=0 on entry; pc frozen; halted=1; redirects ignored. Exit only by reset.
- Simultaneous redirect and decode stall: redirect wins; latch is flushed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); the first fetch after rst_n rises is 2 cycles later (BOOT cycle, then FETCH).
- if_instr and if_pc hold their values while if_valid=0; decode must ignore them.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0] and output flush_count [15:0], both reset to 0 and saturating at max.
  - fetch_count increments on every latch load (handshake-accepted fetch).
  - flush_count increments on every redirect that discards a valid latch or an in-flight fetch.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset/boot: memory word0=0x004182b3, word1=0x40418333, id_ready=1 -> cycle 1 if_valid=0; cycle 2 if_instr=0x004182b3, if_pc=0; cycle 3 if_instr=0x40418333, if_pc=4.
- Stall: drop id_ready for 3 cycles while if_pc=8 -> if_pc stays 8, imem_addr stays 3; on release, if_pc=12 next cycle.
- Redirect: redirect_valid=1, redirect_pc=0x1C while if_pc=4 and id_ready=0 -> next cycle if_valid=0; following cycle if_pc=0x1C, if_instr=word7 (0x0020A103).
- Misaligned redirect: redirect_pc=0x22 -> fetch_err=1, halted=1, if_valid=0; redirects and id_ready are ignored thereafter.
- Overflow: IMEM_DEPTH=4, sequential run -> words 0..3 delivered, then HALT with fetch_err=1 and no 5th valid.
- Async reset mid-stream: pulse rst_n low mid-cycle at if_pc=0x10 -> outputs clear immediately; refetch restarts at pc=0. With FETCH_PERF_CNT_EN defined, fetch_count=0 after reset.
